seven_seg_scan_ctrl: RTL
========================

Name: seven_seg_scan_ctrl

Overview:
- Parametrised time-multiplexed hex display driver for the board's common-anode 7-segment display. Next generation of the 4-digit scanner.
- Generalised to NUM_DIGITS digits with an internal refresh prescaler, a load-strobed display register, per-digit blanking, decimal points and 16-level PWM brightness.
- Sits at the top level between the datapath debug buses (result, PC) and the board segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8); display value width is 4*NUM_DIGITS.
- REFRESH_LOG2, 16, log2 of clock cycles each digit slot lasts (>=4); slot period P = 2**REFRESH_LOG2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- load  in  1  when 1, value_q <= value this cycle.
- value  in  4*NUM_DIGITS  hex value; nibble k shown on digit k (digit 0 = rightmost).
- blank_mask  in  NUM_DIGITS  bit k = 1 forces digit k dark.
- dp_mask  in  NUM_DIGITS  bit k = 1 lights decimal point of digit k.
- bright  in  4  brightness, 0 = 1/16 duty, 15 = full.
- seg  out  7  segments {a,b,c,d,e,f,g}, a = bit 6, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  digit enables, active-low, one-hot-cold.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (sync, reset=1 at edge): div_cnt=0, idx=0, value_q=0, seg=7'h7F, dp=1, an=all 1s, frame_done=0. Reset has priority over load and scan; mid-scan reset restarts at digit 0 on the next cycle.
- Prescaler: div_cnt (REFRESH_LOG2 bits) increments every cycle and wraps naturally. tick = (div_cnt == P-1).
- Digit index: on tick, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1. It never takes values >= NUM_DIGITS.
- frame_done: registered; equals 1 exactly in the cycle after the tick that wraps idx from NUM_DIGITS-1 to 0.
- Display register: value_q updates on load. Outputs use value_q only.
  - A load in cycle n is visible on seg from cycle n+2 (register plus output register).
  - A load coinciding with tick is legal; no glitch beyond normal latency.
- Lit condition: lit = !blank_mask[idx] && (div_cnt[REFRESH_LOG2-1 -: 4] <= bright).
- Outputs are registered, one cycle latency from idx/div_cnt/value_q:
  - lit: an = ~(1 << idx); seg = decode(value_q nibble idx); dp = ~dp_mask[idx].
  - not lit: an = all 1s, seg = 7'h7F, dp = 1.
- Decode (hex, active-low):
  - 0:01, 1:4F, 2:12, 3:06, 4:4C, 5:24, 6:20, 7:0F
  - 8:00, 9:0C, A:08, b:60, C:31, d:42, E:30, F:38
- At most one an bit is low in any cycle. Changes on blank_mask, dp_mask and bright take effect after one cycle.

Optional Feature:
- Macro SEVEN_SEG_LZB_EN.
- Defined: adds input port lzb (1 bit). When lzb=1, digit k (k>0) is treated as blanked if nibbles k..NUM_DIGITS-1 of value_q are all zero. Digit 0 is never blanked by lzb. The condition ORs with blank_mask; dp_mask is still honoured only when the digit is lit.
- Undefined: no lzb port, no leading-zero logic.

Test Plan (NUM_DIGITS=4, REFRESH_LOG2=4, P=16):
- Reset: hold reset 3 cycles with load=1, value=16'hFFFF -> an=4'hF, seg=7'h7F, dp=1, frame_done=0. After release, value_q=0; with bright=15, first lit cycle shows an=4'b1110, seg=7'h01.
- Scan order: load 16'h12AF, bright=15, masks 0 -> repeating 16-cycle slots an=1110/seg=38, 1101/08, 1011/12, 0111/4F. frame_done pulses once every 64 cycles, one cycle after slot 3 ends.
- PWM: bright=3 -> in each slot an is active for cycles with div_cnt upper nibble 0..3 only. Since REFRESH_LOG2=4, that nibble is div_cnt itself, so an is active 4 of 16 cycles. bright=0 gives 1 of 16 cycles; the other cycles read an=4'hF, seg=7'h7F.
- Blank/dp: blank_mask=4'b0100, dp_mask=4'b0001 -> an[2] never low; dp=0 only while an=4'b1110.
- Load at tick: load 16'h0005 in the same cycle as tick during slot 0 -> the slot-1 digit shows the new nibble (seg=7'h01) from its first lit cycle; no cycle shows two an bits low.
- Reset mid-scan during slot 2 -> next cycle outputs are reset values, and scan restarts at an=4'b1110 with value 0. With SEVEN_SEG_LZB_EN, lzb=1 and value 16'h0005 -> only digit 0 ever lit (seg=7'h24).

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed hex scanner for a common-anode 7-segment display with PWM brightness.
// Define SEVEN_SEG_LZB_EN to add the lzb input for leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_LOG2 = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [3:0]              bright,
`ifdef SEVEN_SEG_LZB_EN
  input  logic                    lzb,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  logic [REFRESH_LOG2-1:0] div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic                    lit;
  logic [3:0]              bright_phase;
  logic [3:0]              nibbles [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_blank;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'h7F;
    unique case (nib)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h0C;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
    endcase
    return s;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nibbles[k] = value_q[4*k +: 4];
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  // Walk from the most significant digit down; a digit is blanked while
  // it and every digit above it are zero. Digit 0 always stays visible.
  always_comb begin
    logic upper_zero;
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero  = upper_zero & (nibbles[k] == 4'h0);
      lz_blank[k] = lzb & upper_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign tick         = (div_cnt_q == '1);
  // The top four prescaler bits form the PWM phase within a digit slot.
  assign bright_phase = div_cnt_q[REFRESH_LOG2-1 -: 4];
  assign lit          = !(blank_mask[idx_q] | lz_blank[idx_q]) && (bright_phase <= bright);

  always_comb begin
    div_cnt_d    = div_cnt_q + REFRESH_LOG2'(1);
    idx_d        = idx_q;
    value_d      = value_q;
    frame_done_d = 1'b0;
    if (tick) begin
      if (idx_q == LastIdx) begin
        idx_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
    if (load) begin
      value_d = value;
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      seg_d       = hex_decode(nibbles[idx_q]);
      dp_d        = ~dp_mask[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      value_q      <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      value_q      <= value_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
